serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around a single full-adder cell and a registered carry. It processes one bit per clock, LSB first. Operands and carry-in are captured on a start pulse. The result is presented with a one-cycle done strobe. It is the sequential consumer of the 1-bit full-adder stage and replaces a ripple chain where area matters more than latency.

---
 rtl/serial_adder.sv | 97 +++++++++
 tb/tb_serial_adder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell and a registered carry,
// one bit per clock LSB first, with a one-cycle done strobe per result.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Full-adder cell on the current LSBs plus the next sum-shift image
  logic             bit_s;
  logic             carry_nxt;
  logic [WIDTH-1:0] s_shift;

  always_comb begin
    bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    s_shift   = (s_sh >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            s_sh  <= '0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_shift;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          // Last bit: publish result; partial values never reach sum/cout
          if (cnt == LAST) begin
            sum   <= s_shift;
            cout  <= carry_nxt;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: driver pushes expected {cout,sum} and
// done cycle; a negedge monitor pops and compares on every done strobe.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [W:0] exp_q[$];
  int         cyc_q[$];
  logic [W:0] last_res = '0;
  logic [W:0] mon_e;
  int         mon_t;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer addition
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Monitor: result and timing on done; held result while busy
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d got={%b,%h}", cyc, cout, sum);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = cyc_q.pop_front();
          if ({cout, sum} !== mon_e) begin
            errors++;
            $display("FAIL result cyc=%0d got={%b,%h} want={%b,%h}", cyc, cout, sum,
                     mon_e[W], mon_e[W-1:0]);
          end
          checks++;
          if (cyc != mon_t) begin
            errors++;
            $display("FAIL done_timing got_cyc=%0d want_cyc=%0d", cyc, mon_t);
          end
          last_res = mon_e;
        end
      end else if (busy) begin
        checks++;
        if ({cout, sum} !== last_res) begin
          errors++;
          $display("FAIL held_result cyc=%0d got={%b,%h} want={%b,%h}", cyc, cout, sum,
                   last_res[W], last_res[W-1:0]);
        end
      end
    end
  end

  task automatic start_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          input logic ci, input bit push);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout got=%b want=0", busy);
    end
    a = ai;
    b = bi;
    cin = ci;
    start = 1'b1;
    if (push) begin
      exp_q.push_back(model(ai, bi, ci));
      cyc_q.push_back(cyc + 1 + W);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b sum=%h cout=%b want all zero",
               name, busy, done, sum, cout);
    end
  endtask

  initial begin
    int k;
    #12;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    start_op(8'h00, 8'h00, 1'b0, 1);
    start_op(8'hFF, 8'h01, 1'b0, 1);
    start_op(8'h3C, 8'h42, 1'b0, 1);
    start_op(8'hA5, 8'h5A, 1'b1, 1);
    drain();

    // Extra start pulses and operand changes during RUN must be ignored
    start_op(8'h10, 8'h20, 1'b0, 1);
    @(negedge clk);
    a = 8'hEE; b = 8'h77; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset in the middle of RUN discards the operation
    start_op(8'hFF, 8'hFF, 1'b0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    last_res = '0;
    #1 check_zero("mid_run_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    start_op(8'h01, 8'h01, 1'b1, 1);
    drain();

    // start held through DONE: second op accepted in the DONE cycle
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    k = cyc + 1;
    exp_q.push_back(model(8'h80, 8'h80, 1'b0));
    cyc_q.push_back(k + W);
    exp_q.push_back(model(8'h80, 8'h80, 1'b0));
    cyc_q.push_back(k + W + 1 + W);
    while (cyc < k + W + 1) @(negedge clk);
    start = 1'b0;
    drain();

    // Random sweep, issued back to back
    for (int i = 0; i < 40; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom), 1);
    end
    drain();
    start_op(8'hFF, 8'hFF, 1'b1, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
